// File: rtl/pb_debounce.sv
// Pushbutton debouncer: two-flop synchronizer, four-state debounce FSM,
// press/release strobes, long-press detect and a wrapping press counter.
module pb_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 64,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_raw,
  output logic       button_press,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic [7:0] press_count
);

  localparam logic [15:0] StableLast = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] HoldMax    = 16'(LONG_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  state_e      state_q;
  logic [1:0]  sync_q;
  logic [15:0] stable_q;
  logic [15:0] hold_q;
  logic [15:0] hold_inc;
  logic        s;

  // Synchronizer resets to the idle pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[0], button_raw};
    end
  end

  assign s        = sync_q[1] ^ ACTIVE_LOW;
  assign hold_inc = (hold_q == HoldMax) ? hold_q : hold_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      stable_q      <= '0;
      hold_q        <= '0;
      button_press  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      press_count   <= '0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s) begin
            state_q  <= StPressWait;
            stable_q <= '0;
          end
        end
        StPressWait: begin
          if (!s) begin
            state_q  <= StIdle;
            stable_q <= '0;
          end else if (stable_q == StableLast) begin
            state_q      <= StPressed;
            button_press <= 1'b1;
            press_pulse  <= 1'b1;
            press_count  <= press_count + 8'd1;
            hold_q       <= '0;
          end else begin
            stable_q <= stable_q + 16'd1;
          end
        end
        StPressed: begin
          hold_q <= hold_inc;
          if (hold_inc == HoldMax) long_press <= 1'b1;
          if (!s) begin
            state_q  <= StReleaseWait;
            stable_q <= '0;
          end
        end
        StReleaseWait: begin
          // Hold time keeps accruing while a release is still unconfirmed.
          hold_q <= hold_inc;
          if (hold_inc == HoldMax) long_press <= 1'b1;
          if (s) begin
            state_q  <= StPressed;
            stable_q <= '0;
          end else if (stable_q == StableLast) begin
            state_q       <= StIdle;
            button_press  <= 1'b0;
            long_press    <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            stable_q <= stable_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_debounce.sv
// Directed bench: one active-high and one active-low instance driven with
// complementary pins, so both must always produce identical outputs.
module tb_pb_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       raw = 1'b0;
  logic       raw_n;
  logic       bp0, pp0, rp0, lp0;
  logic       bp1, pp1, rp1, lp1;
  logic [7:0] pc0, pc1;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned npp0 = 0, nrp0 = 0, npp1 = 0, nrp1 = 0, n_both = 0;
  int unsigned snap_pp, snap_rp;

  assign raw_n = ~raw;

  always #5 clk = ~clk;

  pb_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(8), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .button_raw(raw),
    .button_press(bp0), .press_pulse(pp0), .release_pulse(rp0),
    .long_press(lp0), .press_count(pc0)
  );

  pb_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(8), .ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .button_raw(raw_n),
    .button_press(bp1), .press_pulse(pp1), .release_pulse(rp1),
    .long_press(lp1), .press_count(pc1)
  );

  always @(negedge clk) begin
    if (pp0) npp0++;
    if (rp0) nrp0++;
    if (pp1) npp1++;
    if (rp1) nrp1++;
    if ((pp0 && rp0) || (pp1 && rp1)) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic bp, input logic pp, input logic rp,
                            input logic lp, input logic [7:0] pc);
    check({tag, " hi.button_press"}, 32'(bp0), 32'(bp));
    check({tag, " hi.press_pulse"}, 32'(pp0), 32'(pp));
    check({tag, " hi.release_pulse"}, 32'(rp0), 32'(rp));
    check({tag, " hi.long_press"}, 32'(lp0), 32'(lp));
    check({tag, " hi.press_count"}, 32'(pc0), 32'(pc));
    check({tag, " lo.button_press"}, 32'(bp1), 32'(bp));
    check({tag, " lo.press_pulse"}, 32'(pp1), 32'(pp));
    check({tag, " lo.release_pulse"}, 32'(rp1), 32'(rp));
    check({tag, " lo.long_press"}, 32'(lp1), 32'(lp));
    check({tag, " lo.press_count"}, 32'(pc1), 32'(pc));
  endtask

  // Leaves time at 1 unit after the n-th rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick(3);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    tick(3);
    check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Clean press: accepted on edge 7, long press on edge 15.
    raw = 1'b1;
    tick(6);
    check_outs("press e6", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    check_outs("press e7", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    tick(1);
    check_outs("press e8", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tick(6);
    check_outs("hold e14", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tick(1);
    check_outs("hold e15", 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    tick(5);

    // Release after long press.
    raw = 1'b0;
    tick(6);
    check_outs("release e6", 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    tick(1);
    check_outs("release e7", 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    tick(1);
    check_outs("release e8", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // Bounce: never more than two consecutive pressed samples.
    snap_pp = npp0;
    snap_rp = nrp0;
    for (int i = 0; i < 5; i++) begin
      raw = 1'b1;
      tick(2);
      raw = 1'b0;
      tick(1);
    end
    tick(10);
    check_outs("bounce", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    check("bounce press strobes", npp0 - snap_pp, 0);
    check("bounce release strobes", nrp0 - snap_rp, 0);

    // One-cycle glitch low while pressed must not release.
    raw = 1'b1;
    tick(7);
    check_outs("press2 e7", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    raw = 1'b0;
    tick(1);
    raw = 1'b1;
    tick(9);
    check_outs("glitch", 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    check("glitch release strobes", nrp0 - snap_rp, 0);
    raw = 1'b0;
    tick(7);
    check_outs("release2 e7", 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
    tick(2);

    // Wrap: 256 pairs from a fresh reset.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    npp0 = 0; nrp0 = 0; npp1 = 0; nrp1 = 0;
    for (int i = 0; i < 256; i++) begin
      raw = 1'b1;
      tick(10);
      raw = 1'b0;
      tick(10);
      if (i == 254) check_outs("wrap 255", 1'b0, 1'b0, 1'b0, 1'b0, 8'd255);
    end
    check_outs("wrap 256", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    check("wrap hi press strobes", npp0, 256);
    check("wrap hi release strobes", nrp0, 256);
    check("wrap lo press strobes", npp1, 256);
    check("wrap lo release strobes", nrp1, 256);

    // Reset mid-press clears immediately with no release strobe.
    raw = 1'b1;
    tick(8);
    check_outs("pre-reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    snap_rp = nrp0;
    rst_n = 1'b0;
    #1;
    check_outs("async reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(2);
    check("reset release strobes", nrp0 - snap_rp, 0);
    rst_n = 1'b1;
    snap_pp = npp0;
    tick(6);
    check_outs("post-reset e6", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    check_outs("post-reset e7", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    tick(4);
    check("post-reset press strobes", npp0 - snap_pp, 1);
    check("pulses overlap", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
